// File: rtl/timer_pkg.sv
// Shared types and helpers for the tick-driven BCD timer.
package timer_pkg;

    localparam int   DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    // Clamp a raw nibble into the legal BCD range so the count never holds 0xA..0xF.
    function automatic bcd_t bcd_sat(input bcd_t raw);
        bcd_t res;
        if (raw > BCD_MAX) begin
            res = BCD_MAX;
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with saturating load and chained increment/decrement.
// Carry/borrow ripple from digit 0 upward; a digit moves only when every lower
// digit is rolling over, signalled by carry_in/borrow_in.
module bcd_digit
    import timer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc,
    input  logic dec,
    input  logic carry_in,
    input  logic borrow_in,
    output bcd_t q,
    output logic carry_out,
    output logic borrow_out,
    output logic is_zero
);

    bcd_t q_d;
    bcd_t q_q;
    logic is_max_s;

    assign is_max_s   = (q_q == BCD_MAX);
    assign is_zero    = (q_q == 4'd0);
    assign carry_out  = carry_in & is_max_s;
    assign borrow_out = borrow_in & is_zero;
    assign q          = q_q;

    // Next digit value: clear, saturating load, then increment/decrement with wrap.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (load) begin
            q_d = bcd_sat(load_val);
        end else if (inc && carry_in) begin
            q_d = is_max_s ? 4'd0 : (q_q + 4'd1);
        end else if (dec && borrow_in) begin
            q_d = is_zero ? BCD_MAX : (q_q - 4'd1);
        end else begin
            q_d = q_q;
        end
    end

    // Digit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/tick_bcd_timer.sv
// Multi-digit BCD up/down timer advanced by rising edges of an asynchronous slow
// clock that is sampled as data. Holds the synchroniser, edge detector, running
// flag, command priority decode and the registered done/wrapped event pulses.
module tick_bcd_timer
    import timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slow_clk,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  tick,
    output logic                  done,
    output logic                  wrapped
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_d;
    logic                   prev_q;
    logic                   running_d;
    logic                   running_q;
    logic                   done_d;
    logic                   done_q;
    logic                   wrapped_d;
    logic                   wrapped_q;

    logic                   tick_s;
    logic                   adv_s;
    logic                   inc_s;
    logic                   dec_s;
    logic                   all_max_s;
    logic                   all_zero_s;
    logic                   upper_zero_s;
    logic                   cnt_one_s;
    logic [DIGITS:0]        carry_s;
    logic [DIGITS:0]        borrow_s;
    logic [DIGITS-1:0]      is_zero_s;
    logic [4*DIGITS-1:0]    count_s;

    assign tick_s      = sync_q[SYNC_STAGES-1] & ~prev_q;
    // Only a tick that survives every higher-priority command moves the count.
    assign adv_s       = tick_s & running_q & ~clear & ~load & ~stop;
    assign inc_s       = adv_s & dir;
    // At zero a down-advance only terminates; it never rolls over to all-9s.
    assign dec_s       = adv_s & ~dir & ~all_zero_s;
    assign carry_s[0]  = 1'b1;
    assign borrow_s[0] = 1'b1;
    assign all_max_s   = carry_s[DIGITS];
    assign all_zero_s  = borrow_s[DIGITS];
    assign cnt_one_s   = (count_s[3:0] == 4'd1) & upper_zero_s;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .clr        (clear),
                .load       (load & ~clear),
                .load_val   (load_val[4*gi +: 4]),
                .inc        (inc_s),
                .dec        (dec_s),
                .carry_in   (carry_s[gi]),
                .borrow_in  (borrow_s[gi]),
                .q          (count_s[4*gi +: 4]),
                .carry_out  (carry_s[gi+1]),
                .borrow_out (borrow_s[gi+1]),
                .is_zero    (is_zero_s[gi])
            );
        end
    endgenerate

    // Detect that every digit above digit 0 is zero (count reduces to digit 0 alone).
    always_comb begin
        upper_zero_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero_s = upper_zero_s & (is_zero_s[i] | (i == 0));
        end
    end

    // Synchroniser shift, edge history, running flag and event pulses.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], slow_clk};
        prev_d    = sync_q[SYNC_STAGES-1];
        running_d = running_q;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        if (clear) begin
            running_d = 1'b0;
        end else if (load) begin
            running_d = running_q;
        end else if (stop) begin
            running_d = 1'b0;
        end else if (start) begin
            // Starting a down-count already at zero would finish immediately; ignore it.
            running_d = dir | ~all_zero_s;
        end else if (adv_s && !dir && (cnt_one_s || all_zero_s)) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end else if (adv_s && dir && all_max_s) begin
            wrapped_d = 1'b1;
        end else begin
            running_d = running_q;
        end
    end

    // Control and synchroniser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            running_q <= running_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_s;
    assign running = running_q;
    assign tick    = tick_s;
    assign done    = done_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Scoreboard bench for tick_bcd_timer: the stimulus thread pushes the expected
// outputs for each clock cycle; a monitor pops and compares them mid-cycle.
module tb_tick_bcd_timer;

    logic        clk;
    logic        rst;
    logic        slow_clk;
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        dir;
    logic [15:0] count;
    logic        running;
    logic        tick;
    logic        done;
    logic        wrapped;

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] cnt;
        logic        run;
        logic        tk;
        logic        dn;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   stim_done;

    tick_bcd_timer #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .count    (count),
        .running  (running),
        .tick     (tick),
        .done     (done),
        .wrapped  (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_checks = n_checks + 1;
                if (count !== e.cnt || running !== e.run || tick !== e.tk ||
                    done !== e.dn || wrapped !== e.wr) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got count=%h running=%b tick=%b done=%b wrapped=%b, want count=%h running=%b tick=%b done=%b wrapped=%b",
                             e.nm, count, running, tick, done, wrapped,
                             e.cnt, e.run, e.tk, e.dn, e.wr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [15:0] c, input logic r,
                              input logic t, input logic d, input logic w);
        exp_t e;
        e.cyc = cyc;
        e.nm  = nm;
        e.cnt = c;
        e.run = r;
        e.tk  = t;
        e.dn  = d;
        e.wr  = w;
        exp_q.push_back(e);
    endtask

    // One slow_clk rising edge: tick one cycle after the first sampling edge,
    // count/flags updated at the following edge, then let the chain fall back.
    task automatic rise(input string nm, input logic [15:0] old_c, input logic [15:0] new_c,
                        input logic run_b, input logic run_a, input logic d, input logic w);
        slow_clk = 1'b1;
        step(); expect_now({nm, "_sample"}, old_c, run_b, 1'b0, 1'b0, 1'b0);
        step(); expect_now({nm, "_tick"},   old_c, run_b, 1'b1, 1'b0, 1'b0);
        step(); expect_now({nm, "_adv"},    new_c, run_a, 1'b0, d, w);
        slow_clk = 1'b0;
        step(); expect_now({nm, "_hold1"},  new_c, run_a, 1'b0, 1'b0, 1'b0);
        step(); expect_now({nm, "_hold2"},  new_c, run_a, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; stim_done = 1'b0;
        rst = 1'b1; slow_clk = 1'b0; start = 1'b0; stop = 1'b0;
        clear = 1'b0; load = 1'b0; load_val = 16'h0000; dir = 1'b0;

        // 1: reset held while slow_clk toggles.
        for (int i = 0; i < 6; i++) begin
            slow_clk = ~slow_clk;
            step(); expect_now("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        slow_clk = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        expect_now("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: count down 3 -> 0, done, then an idle tick.
        load = 1'b1; load_val = 16'h0003;
        step(); expect_now("load_0003", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; dir = 1'b0; start = 1'b1;
        step(); expect_now("start_down", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        rise("dn_3to2", 16'h0003, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        rise("dn_2to1", 16'h0002, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        rise("dn_1to0", 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        rise("idle_tick", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: count up through the all-9s wrap.
        load = 1'b1; load_val = 16'h9998;
        step(); expect_now("load_9998", 16'h9998, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; dir = 1'b1; start = 1'b1;
        step(); expect_now("start_up", 16'h9998, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        rise("up_9999", 16'h9998, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b0);
        rise("up_wrap", 16'h9999, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // 4: saturating load, then clear+load on a tick cycle.
        load = 1'b1; load_val = 16'hA0F5;
        step(); expect_now("load_sat", 16'h9095, 1'b1, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        slow_clk = 1'b1;
        step(); expect_now("clr_sample", 16'h9095, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); expect_now("clr_tick", 16'h9095, 1'b1, 1'b1, 1'b0, 1'b0);
        clear = 1'b1; load = 1'b1; load_val = 16'h1234;
        step(); expect_now("clr_wins", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0; load = 1'b0; slow_clk = 1'b0;
        step(); step(); expect_now("clr_settle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: start&stop together, stop beats a tick, down-start at zero ignored.
        load = 1'b1; load_val = 16'h0005;
        step(); expect_now("load_0005", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1; stop = 1'b1;
        step(); expect_now("start_stop", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0; dir = 1'b1;
        step(); expect_now("restart", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        slow_clk = 1'b1;
        step(); expect_now("stop_sample", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); expect_now("stop_tick", 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step(); expect_now("stop_noadv", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0; slow_clk = 1'b0;
        step(); step();
        clear = 1'b1;
        step(); expect_now("clear", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0; dir = 1'b0; start = 1'b1;
        step(); expect_now("start_zero_dn", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step(); expect_now("start_zero_dn2", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: async reset mid-count with a rise already in the synchroniser.
        load = 1'b1; load_val = 16'h0042;
        step(); expect_now("load_0042", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; dir = 1'b1; start = 1'b1;
        step(); expect_now("start_42", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        slow_clk = 1'b1;
        step();
        rst = 1'b1;
        expect_now("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); expect_now("rst_held", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        slow_clk = 1'b0; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_now("no_stale_tick", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise.
    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget = budget + 1;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, stim_done=%0b want 1", stim_done);
        $fatal(1, "timeout");
    end

endmodule
